// File: rtl/lzc_norm_pkg.sv
// Shared constants for the leading-zero normaliser: fixed-point format and
// the count-width helper used wherever a 0..WIDTH count must be held.
package lzc_norm_pkg;

    localparam int unsigned QM = 10;
    localparam int unsigned QN = 10;
    localparam int unsigned FIX_WIDTH = QM + QN;

    // Bits needed to hold any count in 0..w inclusive.
    function automatic int unsigned lzc_width(int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/lzc_core.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module lzc_core
    import lzc_norm_pkg::*;
#(
    parameter int unsigned WIDTH = FIX_WIDTH,
    localparam int unsigned LZW = lzc_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [LZW-1:0]   o_lzc
);

    if (WIDTH < 1) begin : g_bad_width
        $error("lzc_core: WIDTH must be at least 1");
    end

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        o_lzc = LZW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_lzc = LZW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/lzc_norm.sv
// Two-stage leading-zero count and normalise with valid/ready flow control:
// S1 takes magnitude and count, S2 barrel-shifts the magnitude left by it.
module lzc_norm
    import lzc_norm_pkg::*;
#(
    parameter int unsigned WIDTH  = FIX_WIDTH,
    parameter bit          SIGNED = 1'b0,
    localparam int unsigned LZW   = lzc_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [LZW-1:0]   o_lzc,
    output logic [WIDTH-1:0] o_norm,
    output logic             o_zero,
    output logic             o_sign
);

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("lzc_norm: WIDTH must lie in 2..64");
    end

    logic             adv1, adv2;
    logic             ld1, ld2;
    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic             sign_in;
    logic [WIDTH-1:0] mag;
    logic [LZW-1:0]   lzc_in;
    logic [WIDTH-1:0] mag1_q, mag1_d;
    logic             sign1_q, sign1_d;
    logic [LZW-1:0]   lzc1_q, lzc1_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] norm2_q, norm2_d;
    logic [LZW-1:0]   lzc2_q, lzc2_d;
    logic             zero2_q, zero2_d;
    logic             sign2_q, sign2_d;

    // Negation wraps, so the most-negative operand keeps its own bit pattern.
    always_comb begin
        sign_in = SIGNED && i_data[WIDTH-1];
        mag     = sign_in ? ((~i_data) + WIDTH'(1)) : i_data;
    end

    lzc_core #(
        .WIDTH(WIDTH)
    ) u_lzc_core (
        .i_data(mag),
        .o_lzc (lzc_in)
    );

    // Log-stage shifter; a count of WIDTH shifts everything out, leaving zero.
    always_comb begin
        shifted = mag1_q;
        for (int k = 0; k < LZW; k++) begin
            if (lzc1_q[k]) begin
                shifted = shifted << (1 << k);
            end
        end
    end

    always_comb begin
        adv2 = !v2_q || o_ready;
        adv1 = !v1_q || adv2;
        ld1  = adv1 && i_valid;
        ld2  = adv2 && v1_q;

        v1_d = adv1 ? i_valid : v1_q;
        v2_d = adv2 ? v1_q : v2_q;

        mag1_d  = ld1 ? mag : mag1_q;
        sign1_d = ld1 ? sign_in : sign1_q;
        lzc1_d  = ld1 ? lzc_in : lzc1_q;

        norm2_d = ld2 ? shifted : norm2_q;
        lzc2_d  = ld2 ? lzc1_q : lzc2_q;
        zero2_d = ld2 ? (mag1_q == '0) : zero2_q;
        sign2_d = ld2 ? sign1_q : sign2_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            mag1_q  <= '0;
            sign1_q <= 1'b0;
            lzc1_q  <= '0;
            norm2_q <= '0;
            lzc2_q  <= '0;
            zero2_q <= 1'b0;
            sign2_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            mag1_q  <= mag1_d;
            sign1_q <= sign1_d;
            lzc1_q  <= lzc1_d;
            norm2_q <= norm2_d;
            lzc2_q  <= lzc2_d;
            zero2_q <= zero2_d;
            sign2_q <= sign2_d;
        end
    end

    assign i_ready = adv1;
    assign o_valid = v2_q;
    assign o_lzc   = lzc2_q;
    assign o_norm  = norm2_q;
    assign o_zero  = zero2_q;
    assign o_sign  = sign2_q;

endmodule

// File: tb/tb_lzc_norm.sv
// Bench for lzc_norm: unsigned and signed 20-bit builds plus a 32-bit build,
// checked against a shift-until-MSB model with an in-order scoreboard.
module tb_lzc_norm;

    typedef struct {
        int          lzc;
        logic [63:0] norm;
        bit          zero;
        bit          sign;
    } exp_t;

    logic clk;
    logic reset_n;

    logic        a_valid, a_ready, a_ovalid, a_oready, a_zero, a_sign;
    logic [19:0] a_data, a_norm;
    logic [4:0]  a_lzc;
    logic        b_valid, b_ready, b_ovalid, b_oready, b_zero, b_sign;
    logic [19:0] b_data, b_norm;
    logic [4:0]  b_lzc;
    logic        c_valid, c_ready, c_ovalid, c_oready, c_zero, c_sign;
    logic [31:0] c_data, c_norm;
    logic [5:0]  c_lzc;

    int n_vec = 0;
    int n_bad = 0;
    int a_outs = 0, b_outs = 0, c_outs = 0;
    exp_t qa[$], qb[$], qc[$];

    lzc_norm #(.WIDTH(20), .SIGNED(1'b0)) u_a (
        .clk(clk), .reset_n(reset_n), .i_valid(a_valid), .i_ready(a_ready), .i_data(a_data),
        .o_valid(a_ovalid), .o_ready(a_oready), .o_lzc(a_lzc), .o_norm(a_norm),
        .o_zero(a_zero), .o_sign(a_sign)
    );
    lzc_norm #(.WIDTH(20), .SIGNED(1'b1)) u_b (
        .clk(clk), .reset_n(reset_n), .i_valid(b_valid), .i_ready(b_ready), .i_data(b_data),
        .o_valid(b_ovalid), .o_ready(b_oready), .o_lzc(b_lzc), .o_norm(b_norm),
        .o_zero(b_zero), .o_sign(b_sign)
    );
    lzc_norm #(.WIDTH(32), .SIGNED(1'b0)) u_c (
        .clk(clk), .reset_n(reset_n), .i_valid(c_valid), .i_ready(c_ready), .i_data(c_data),
        .o_valid(c_ovalid), .o_ready(c_oready), .o_lzc(c_lzc), .o_norm(c_norm),
        .o_zero(c_zero), .o_sign(c_sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Normalise by repeated doubling until the top bit of the w-bit field is set.
    function automatic exp_t model(logic [63:0] d, int w, bit sgn);
        exp_t        e;
        logic [63:0] mask;
        logic [63:0] mag;
        mask   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        d      = d & mask;
        e.sign = sgn && d[w-1];
        mag    = e.sign ? ((~d + 64'd1) & mask) : d;
        e.zero = (mag == 64'd0);
        e.norm = mag;
        e.lzc  = 0;
        if (e.zero) begin
            e.lzc = w;
        end else begin
            while (!e.norm[w-1]) begin
                e.norm = (e.norm << 1) & mask;
                e.lzc++;
            end
        end
        return e;
    endfunction

    task automatic check_res(string name, exp_t e, int lzc, logic [63:0] norm, bit zero,
                             bit sign);
        n_vec++;
        if (lzc != e.lzc || norm != e.norm || zero != e.zero || sign != e.sign) begin
            n_bad++;
            $display("FAIL %s: got lzc=%0d norm=%h zero=%0d sign=%0d, want lzc=%0d norm=%h zero=%0d sign=%0d",
                     name, lzc, norm, zero, sign, e.lzc, e.norm, e.zero, e.sign);
        end
    endtask

    task automatic check_val(string name, logic [63:0] got, logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic pin(string name, logic [63:0] d, int w, bit s, int lzc, logic [63:0] norm,
                       bit zero, bit sign);
        exp_t m;
        exp_t e;
        m = model(d, w, s);
        e = '{lzc, norm, zero, sign};
        check_res(name, e, m.lzc, m.norm, m.zero, m.sign);
    endtask

    // Called just after a rising edge; leaves i_valid high once accepted.
    task automatic send(int u, logic [63:0] d);
        int n;
        bit acc;
        n = 0;
        case (u)
            0:       begin a_valid = 1'b1; a_data = d[19:0]; end
            1:       begin b_valid = 1'b1; b_data = d[19:0]; end
            default: begin c_valid = 1'b1; c_data = d[31:0]; end
        endcase
        do begin
            @(negedge clk);
            acc = (u == 0) ? a_ready : (u == 1) ? b_ready : c_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        check_val("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic directed_a(string name, logic [19:0] d, int lzc, logic [19:0] norm, bit zero);
        exp_t e;
        @(posedge clk);
        #1;
        a_valid = 1'b1;
        a_data  = d;
        @(negedge clk);
        check_val({name, "_ready"}, 64'(a_ready), 64'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_data  = 20'($urandom);
        @(negedge clk);
        check_val({name, "_early"}, 64'(a_ovalid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_val({name, "_valid"}, 64'(a_ovalid), 64'd1);
        e = '{lzc, 64'(norm), zero, 1'b0};
        check_res(name, e, int'(a_lzc), 64'(a_norm), a_zero, a_sign);
    endtask

    // Scoreboard for u_a: ready rule, stall stability, ordered results.
    initial begin : mon_a
        bit          stall;
        logic [63:0] held;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                qa.delete();
                stall = 1'b0;
            end else begin
                check_val("a_iready", 64'(a_ready), 64'((qa.size() < 2) || a_oready));
                if (stall) check_val("a_hold", 64'({a_lzc, a_norm, a_zero, a_sign}), held);
                if (a_ovalid && a_oready) begin
                    a_outs++;
                    if (qa.size() == 0) check_val("a_stale", 64'(a_ovalid), 64'd0);
                    else check_res("a_result", qa.pop_front(), int'(a_lzc), 64'(a_norm),
                                   a_zero, a_sign);
                end
                if (a_valid && a_ready) qa.push_back(model(64'(a_data), 20, 1'b0));
                stall = a_ovalid && !a_oready;
                held  = 64'({a_lzc, a_norm, a_zero, a_sign});
            end
        end
    end

    initial begin : mon_b
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                qb.delete();
            end else begin
                if (b_ovalid && b_oready) begin
                    b_outs++;
                    if (qb.size() == 0) check_val("b_stale", 64'(b_ovalid), 64'd0);
                    else check_res("b_result", qb.pop_front(), int'(b_lzc), 64'(b_norm),
                                   b_zero, b_sign);
                end
                if (b_valid && b_ready) qb.push_back(model(64'(b_data), 20, 1'b1));
            end
        end
    end

    initial begin : mon_c
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                qc.delete();
            end else begin
                if (c_ovalid && c_oready) begin
                    c_outs++;
                    if (qc.size() == 0) check_val("c_stale", 64'(c_ovalid), 64'd0);
                    else check_res("c_result", qc.pop_front(), int'(c_lzc), 64'(c_norm),
                                   c_zero, c_sign);
                end
                if (c_valid && c_ready) qc.push_back(model(64'(c_data), 32, 1'b0));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int start;
        reset_n  = 1'b0;
        a_valid  = 1'b0; a_data = '0; a_oready = 1'b1;
        b_valid  = 1'b0; b_data = '0; b_oready = 1'b1;
        c_valid  = 1'b0; c_data = '0; c_oready = 1'b1;

        pin("pin_u_one", 64'h00001, 20, 1'b0, 19, 64'h80000, 1'b0, 1'b0);
        pin("pin_u_msb", 64'h80000, 20, 1'b0, 0, 64'h80000, 1'b0, 1'b0);
        pin("pin_u_zero", 64'h00000, 20, 1'b0, 20, 64'h0, 1'b1, 1'b0);
        pin("pin_s_m1", 64'hFFFFF, 20, 1'b1, 19, 64'h80000, 1'b0, 1'b1);
        pin("pin_s_min", 64'h80000, 20, 1'b1, 0, 64'h80000, 1'b0, 1'b1);
        pin("pin_s_three", 64'h00C00, 20, 1'b1, 8, 64'hC0000, 1'b0, 1'b0);
        pin("pin_s_mix", 64'h12345, 20, 1'b1, 3, 64'h91A28, 1'b0, 1'b0);
        pin("pin_s_m2", 64'hFFFFE, 20, 1'b1, 18, 64'h80000, 1'b0, 1'b1);
        pin("pin_32_one", 64'h1, 32, 1'b0, 31, 64'h80000000, 1'b0, 1'b0);
        pin("pin_32_zero", 64'h0, 32, 1'b0, 32, 64'h0, 1'b1, 1'b0);

        #3;
        check_val("rst_outputs", 64'({a_ovalid, a_lzc, a_norm, a_zero, a_sign}), 64'd0);
        check_val("rst_valid_bc", 64'({b_ovalid, c_ovalid}), 64'd0);
        #19;
        reset_n = 1'b1;
        #1;
        check_val("rst_iready", 64'({a_ready, b_ready, c_ready}), 64'b111);

        directed_a("u_one", 20'h00001, 19, 20'h80000, 1'b0);
        directed_a("u_msb", 20'h80000, 0, 20'h80000, 1'b0);
        directed_a("u_zero", 20'h00000, 20, 20'h00000, 1'b1);

        @(posedge clk);
        #1;
        send(1, 64'hFFFFF);
        send(1, 64'h80000);
        send(1, 64'h00C00);
        send(1, 64'h12345);
        send(1, 64'hFFFFE);
        b_valid = 1'b0;
        for (int k = 31; k >= 0; k--) send(2, 64'd1 << k);
        send(2, 64'd0);
        c_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_val("b_count", 64'(b_outs), 64'd5);
        check_val("c_count", 64'(c_outs), 64'd33);

        // Full throughput: one result per cycle, first two cycles after presentation.
        start = a_outs;
        @(posedge clk);
        #1;
        a_valid = 1'b1;
        a_data  = 20'($urandom);
        for (int j = 0; j < 104; j++) begin
            @(negedge clk);
            check_val("tput_ovalid", 64'(a_ovalid), 64'(j >= 2 && j < 102));
            @(posedge clk);
            #1;
            if (j + 1 < 100) a_data = 20'($urandom);
            else a_valid = 1'b0;
        end
        check_val("tput_count", 64'(a_outs - start), 64'd100);

        // Back-pressure: hold o_ready low first so both stages fill, then toggle.
        start = a_outs;
        fork
            begin
                @(posedge clk);
                #1;
                for (int i = 0; i < 8; i++) send(0, 64'($urandom));
                a_valid = 1'b0;
            end
            begin
                a_oready = 1'b0;
                repeat (6) begin
                    @(posedge clk);
                    #1;
                end
                for (int k = 0; k < 300 && a_outs - start < 8; k++) begin
                    a_oready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                a_oready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check_val("bp_count", 64'(a_outs - start), 64'd8);

        // Reset with both stages occupied.
        a_oready = 1'b0;
        send(0, 64'h00001);
        send(0, 64'h00002);
        a_valid = 1'b0;
        @(negedge clk);
        check_val("mid_full", 64'(a_ovalid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("mid_async", 64'({a_ovalid, a_lzc, a_norm, a_zero, a_sign}), 64'd0);
        check_val("mid_iready", 64'(a_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset_n  = 1'b1;
        a_oready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check_val("mid_no_stale", 64'(a_ovalid), 64'd0);
        end
        directed_a("post_rst", 20'h00300, 10, 20'hC0000, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check_val("drained", 64'(qa.size() + qb.size() + qc.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
